// File: rtl/gesture_power_fsm_if.sv
// Gesture sequencer bus: window length and gesture levels in, power status and countdown out.
interface gesture_power_fsm_if #(parameter int CNT_W = 32);
  logic [CNT_W-1:0] countdown_time;
  logic             gesture_left;
  logic             gesture_right;
  logic             power_on;
  logic             arming;
  logic             on_pulse;
  logic             off_pulse;
  logic             timeout_pulse;
  logic [CNT_W-1:0] time_left;
  logic [3:0]       remaining_sec;

  modport master (
    output countdown_time, gesture_left, gesture_right,
    input  power_on, arming, on_pulse, off_pulse, timeout_pulse, time_left, remaining_sec
  );

  modport slave (
    input  countdown_time, gesture_left, gesture_right,
    output power_on, arming, on_pulse, off_pulse, timeout_pulse, time_left, remaining_sec
  );
endinterface

// File: rtl/gesture_power_fsm.sv
// Gesture power sequencer: left->right within the window powers on, right->left powers off.
module gesture_power_fsm #(
  parameter int CNT_W  = 32,
  parameter int CLK_HZ = 100_000_000
) (
  input  logic                clk,
  input  logic                reset,
  gesture_power_fsm_if.slave  bus
);
  typedef enum logic [1:0] {S_OFF, S_ARM_ON, S_ON, S_ARM_OFF} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, win;
  logic             left_q, right_q;
  logic             on_pulse_q, on_pulse_d;
  logic             off_pulse_q, off_pulse_d;
  logic             to_pulse_q, to_pulse_d;
  logic             lr, rr, lr_ok, rr_ok;
  logic [3:0]       sec;

  assign lr    = bus.gesture_left  & ~left_q;
  assign rr    = bus.gesture_right & ~right_q;
  // Simultaneous rises are ambiguous, so both are dropped.
  assign lr_ok = lr & ~rr;
  assign rr_ok = rr & ~lr;
  assign win   = (bus.countdown_time == '0) ? CNT_ONE : bus.countdown_time;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    on_pulse_d  = 1'b0;
    off_pulse_d = 1'b0;
    to_pulse_d  = 1'b0;
    case (state_q)
      S_OFF: begin
        if (lr_ok) begin
          state_d = S_ARM_ON;
          cnt_d   = win;
        end
      end
      S_ARM_ON: begin
        if (rr_ok) begin
          state_d    = S_ON;
          cnt_d      = '0;
          on_pulse_d = 1'b1;
        end else if (lr_ok) begin
          cnt_d = win;
        end else if (cnt_q <= CNT_ONE) begin
          state_d    = S_OFF;
          cnt_d      = '0;
          to_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ON: begin
        if (rr_ok) begin
          state_d = S_ARM_OFF;
          cnt_d   = win;
        end
      end
      S_ARM_OFF: begin
        if (lr_ok) begin
          state_d     = S_OFF;
          cnt_d       = '0;
          off_pulse_d = 1'b1;
        end else if (rr_ok) begin
          cnt_d = win;
        end else if (cnt_q <= CNT_ONE) begin
          state_d    = S_ON;
          cnt_d      = '0;
          to_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_OFF;
      cnt_q       <= '0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      on_pulse_q  <= 1'b0;
      off_pulse_q <= 1'b0;
      to_pulse_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_q      <= bus.gesture_left;
      right_q     <= bus.gesture_right;
      on_pulse_q  <= on_pulse_d;
      off_pulse_q <= off_pulse_d;
      to_pulse_q  <= to_pulse_d;
    end
  end

  // Whole seconds left, rounded up and clipped to one 7-seg digit.
  always_comb begin
    sec = 4'd9;
    for (int k = 9; k >= 1; k--) begin
      if (64'(cnt_q) <= 64'(k) * 64'(CLK_HZ)) sec = 4'(k);
    end
    if (cnt_q == '0) sec = 4'd0;
  end

  assign bus.power_on      = (state_q == S_ON) || (state_q == S_ARM_OFF);
  assign bus.arming        = (state_q == S_ARM_ON) || (state_q == S_ARM_OFF);
  assign bus.on_pulse      = on_pulse_q;
  assign bus.off_pulse     = off_pulse_q;
  assign bus.timeout_pulse = to_pulse_q;
  assign bus.time_left     = cnt_q;
  assign bus.remaining_sec = sec;
endmodule

// File: tb/tb_gesture_power_fsm.sv
// Directed bench for gesture_power_fsm with CLK_HZ=10 and a 50-cycle window.
module tb_gesture_power_fsm;
  localparam int CNT_W  = 32;
  localparam int CLK_HZ = 10;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  gesture_power_fsm_if #(.CNT_W(CNT_W)) bus();

  gesture_power_fsm #(.CNT_W(CNT_W), .CLK_HZ(CLK_HZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic l, input logic r);
    bus.gesture_left  = l;
    bus.gesture_right = r;
    tick();
    bus.gesture_left  = 1'b0;
    bus.gesture_right = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.countdown_time = 32'd50;
    bus.gesture_left   = 1'b0;
    bus.gesture_right  = 1'b0;
    tick();
    total++; if ({bus.power_on, bus.arming, bus.on_pulse, bus.off_pulse, bus.timeout_pulse} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b exp=00000", {bus.power_on, bus.arming, bus.on_pulse, bus.off_pulse, bus.timeout_pulse}); end
    total++; if (bus.time_left !== 32'd0 || bus.remaining_sec !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.time_left, bus.remaining_sec); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_timeout_on();
    pulse(1'b1, 1'b0);
    total++; if (bus.arming !== 1'b1 || bus.time_left !== 32'd50) begin bad++; $display("FAIL t2_arm got=%b/%0d exp=1/50", bus.arming, bus.time_left); end
    total++; if (bus.remaining_sec !== 4'd5) begin bad++; $display("FAIL t2_sec5 got=%0d exp=5", bus.remaining_sec); end
    tick();
    total++; if (bus.time_left !== 32'd49) begin bad++; $display("FAIL t2_cnt49 got=%0d exp=49", bus.time_left); end
    bus.countdown_time = 32'd7;
    ticks(47);
    total++; if (bus.time_left !== 32'd2 || bus.remaining_sec !== 4'd1) begin bad++; $display("FAIL t2_cnt2 got=%0d/%0d exp=2/1", bus.time_left, bus.remaining_sec); end
    tick();
    total++; if (bus.time_left !== 32'd1 || bus.timeout_pulse !== 1'b0) begin bad++; $display("FAIL t2_cnt1 got=%0d/%b exp=1/0", bus.time_left, bus.timeout_pulse); end
    tick();
    total++; if (bus.timeout_pulse !== 1'b1 || bus.arming !== 1'b0 || bus.power_on !== 1'b0) begin bad++; $display("FAIL t2_timeout got=%b%b%b exp=100", bus.timeout_pulse, bus.arming, bus.power_on); end
    total++; if (bus.time_left !== 32'd0 || bus.remaining_sec !== 4'd0) begin bad++; $display("FAIL t2_cnt0 got=%0d/%0d exp=0/0", bus.time_left, bus.remaining_sec); end
    tick();
    total++; if (bus.timeout_pulse !== 1'b0) begin bad++; $display("FAIL t2_pulse_len got=%b exp=0", bus.timeout_pulse); end
    bus.countdown_time = 32'd50;
  endtask

  task automatic test_power_on();
    pulse(1'b1, 1'b0);
    ticks(19);
    total++; if (bus.time_left !== 32'd31 || bus.remaining_sec !== 4'd4) begin bad++; $display("FAIL t1_cnt31 got=%0d/%0d exp=31/4", bus.time_left, bus.remaining_sec); end
    pulse(1'b0, 1'b1);
    total++; if (bus.on_pulse !== 1'b1 || bus.power_on !== 1'b1 || bus.arming !== 1'b0) begin bad++; $display("FAIL t1_on got=%b%b%b exp=110", bus.on_pulse, bus.power_on, bus.arming); end
    total++; if (bus.time_left !== 32'd0) begin bad++; $display("FAIL t1_cnt0 got=%0d exp=0", bus.time_left); end
    tick();
    total++; if (bus.on_pulse !== 1'b0 || bus.power_on !== 1'b1) begin bad++; $display("FAIL t1_hold got=%b%b exp=01", bus.on_pulse, bus.power_on); end
  endtask

  task automatic test_off_at_edge_w();
    pulse(1'b0, 1'b1);
    total++; if (bus.arming !== 1'b1 || bus.power_on !== 1'b1 || bus.time_left !== 32'd50) begin bad++; $display("FAIL t3_arm got=%b%b/%0d exp=11/50", bus.arming, bus.power_on, bus.time_left); end
    ticks(49);
    total++; if (bus.time_left !== 32'd1) begin bad++; $display("FAIL t3_cnt1 got=%0d exp=1", bus.time_left); end
    pulse(1'b1, 1'b0);
    total++; if (bus.off_pulse !== 1'b1 || bus.timeout_pulse !== 1'b0 || bus.power_on !== 1'b0 || bus.arming !== 1'b0) begin bad++; $display("FAIL t3_off got=%b%b%b%b exp=1000", bus.off_pulse, bus.timeout_pulse, bus.power_on, bus.arming); end
    tick();
    total++; if (bus.off_pulse !== 1'b0 || bus.power_on !== 1'b0) begin bad++; $display("FAIL t3_hold got=%b%b exp=00", bus.off_pulse, bus.power_on); end
  endtask

  task automatic test_conflict_reload();
    pulse(1'b1, 1'b1);
    total++; if (bus.arming !== 1'b0 || bus.time_left !== 32'd0) begin bad++; $display("FAIL t4_off_conf got=%b/%0d exp=0/0", bus.arming, bus.time_left); end
    tick();
    pulse(1'b1, 1'b0);
    tick();
    pulse(1'b1, 1'b1);
    total++; if (bus.arming !== 1'b1 || bus.time_left !== 32'd48 || bus.on_pulse !== 1'b0) begin bad++; $display("FAIL t4_arm_conf got=%b/%0d/%b exp=1/48/0", bus.arming, bus.time_left, bus.on_pulse); end
    tick();
    pulse(1'b1, 1'b0);
    total++; if (bus.time_left !== 32'd50 || bus.arming !== 1'b1) begin bad++; $display("FAIL t4_reload got=%0d/%b exp=50/1", bus.time_left, bus.arming); end
    tick();
    pulse(1'b0, 1'b1);
    total++; if (bus.on_pulse !== 1'b1 || bus.power_on !== 1'b1) begin bad++; $display("FAIL t4_on got=%b%b exp=11", bus.on_pulse, bus.power_on); end
    tick();
    pulse(1'b0, 1'b1);
    ticks(49);
    total++; if (bus.time_left !== 32'd1 || bus.power_on !== 1'b1) begin bad++; $display("FAIL t4_armoff_cnt got=%0d/%b exp=1/1", bus.time_left, bus.power_on); end
    tick();
    total++; if (bus.timeout_pulse !== 1'b1 || bus.power_on !== 1'b1 || bus.arming !== 1'b0 || bus.time_left !== 32'd0) begin bad++; $display("FAIL t4_armoff_to got=%b%b%b/%0d exp=110/0", bus.timeout_pulse, bus.power_on, bus.arming, bus.time_left); end
    tick();
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b1, 1'b0);
    total++; if (bus.off_pulse !== 1'b1 || bus.power_on !== 1'b0) begin bad++; $display("FAIL t4_off got=%b%b exp=10", bus.off_pulse, bus.power_on); end
    tick();
  endtask

  task automatic test_short_window();
    bus.countdown_time = 32'd200;
    pulse(1'b1, 1'b0);
    total++; if (bus.time_left !== 32'd200 || bus.remaining_sec !== 4'd9) begin bad++; $display("FAIL t5_sat got=%0d/%0d exp=200/9", bus.time_left, bus.remaining_sec); end
    tick();
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b0, 1'b1);
    tick();
    pulse(1'b1, 1'b0);
    tick();
    bus.countdown_time = 32'd0;
    pulse(1'b1, 1'b0);
    total++; if (bus.time_left !== 32'd1 || bus.remaining_sec !== 4'd1 || bus.arming !== 1'b1) begin bad++; $display("FAIL t5_w1 got=%0d/%0d/%b exp=1/1/1", bus.time_left, bus.remaining_sec, bus.arming); end
    pulse(1'b0, 1'b1);
    total++; if (bus.on_pulse !== 1'b1 || bus.power_on !== 1'b1 || bus.timeout_pulse !== 1'b0) begin bad++; $display("FAIL t5_on_e1 got=%b%b%b exp=110", bus.on_pulse, bus.power_on, bus.timeout_pulse); end
    tick();
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    total++; if (bus.off_pulse !== 1'b1 || bus.power_on !== 1'b0) begin bad++; $display("FAIL t5_off_e1 got=%b%b exp=10", bus.off_pulse, bus.power_on); end
    tick();
    pulse(1'b1, 1'b0);
    tick();
    total++; if (bus.timeout_pulse !== 1'b1 || bus.arming !== 1'b0 || bus.power_on !== 1'b0) begin bad++; $display("FAIL t5_to_e1 got=%b%b%b exp=100", bus.timeout_pulse, bus.arming, bus.power_on); end
    bus.countdown_time = 32'd50;
    tick();
  endtask

  task automatic test_reset_mid_window();
    bus.gesture_left = 1'b1;
    tick();
    ticks(20);
    total++; if (bus.time_left !== 32'd30 || bus.arming !== 1'b1) begin bad++; $display("FAIL t6_cnt30 got=%0d/%b exp=30/1", bus.time_left, bus.arming); end
    reset = 1'b0;
    #1;
    total++; if ({bus.power_on, bus.arming, bus.on_pulse, bus.off_pulse, bus.timeout_pulse} !== 5'b0 || bus.time_left !== 32'd0 || bus.remaining_sec !== 4'd0) begin bad++; $display("FAIL t6_async got=%b/%0d/%0d exp=00000/0/0", {bus.power_on, bus.arming, bus.on_pulse, bus.off_pulse, bus.timeout_pulse}, bus.time_left, bus.remaining_sec); end
    bus.gesture_left = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    total++; if (bus.arming !== 1'b0 || bus.time_left !== 32'd0) begin bad++; $display("FAIL t6_after got=%b/%0d exp=0/0", bus.arming, bus.time_left); end
    pulse(1'b1, 1'b0);
    total++; if (bus.arming !== 1'b1 || bus.time_left !== 32'd50) begin bad++; $display("FAIL t6_rearm got=%b/%0d exp=1/50", bus.arming, bus.time_left); end
    tick();
  endtask

  initial begin
    test_reset();
    test_timeout_on();
    test_power_on();
    test_off_at_edge_w();
    test_conflict_reload();
    test_short_window();
    test_reset_mid_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
